ring_decoder: RTL and testbench

Monitors the one-hot phase vector produced by a `ringcounter` and recovers a binary phase index from it. It locks onto the legal phase sequence, counts completed rotations, and flags corrupted patterns, skipped phases and stalls. It sits on the receiving side of the ring-counter phase bus: control logic uses its index, lock and error outputs instead of decoding the one-hot vector ad hoc.

---
 rtl/ring_if.sv | 19 +
 rtl/ring_decoder.sv | 76 +++++++
 tb/tb_ring_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ring_if.sv
// ring_if: phase bus from a ring counter plus the decoded status returned by ring_decoder.
interface ring_if #(
  parameter int N  = 4,
  parameter int IW = $clog2(N),
  parameter int CW = 8
);
  logic [N-1:0]  phase;
  logic          clr;
  logic [IW-1:0] idx;
  logic          valid;
  logic          locked;
  logic          wrap;
  logic          fault;
  logic          err;
  logic          stall;
  logic [CW-1:0] rotations;
  modport master (output phase, clr, input idx, valid, locked, wrap, fault, err, stall, rotations);
  modport slave  (input phase, clr, output idx, valid, locked, wrap, fault, err, stall, rotations);
endinterface

// File: rtl/ring_decoder.sv
// ring_decoder: locks onto a one-hot ring phase, decodes its index, counts rotations, flags faults and stalls.
module ring_decoder #(
  parameter int N           = 4,
  parameter int IW          = $clog2(N),
  parameter int LOCK_CYCLES = 2,
  parameter int STALL_MAX   = 15,
  parameter int CW          = 8
) (
  input logic   clk,
  input logic   reset,
  ring_if.slave bus
);
  localparam int RW = $clog2(LOCK_CYCLES + 1);
  localparam int HW = $clog2(STALL_MAX + 2);
  typedef enum logic {UNLOCKED, LOCKED} state_t;
  state_t        state_q, state_d;
  logic [N-1:0]  ph_q, ph_d;
  logic [RW-1:0] run_q, run_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] rot_q, rot_d;
  logic          valid_q, valid_d, wrap_q, wrap_d, fault_q, fault_d, err_q, err_d;
  logic          s_ok, p_ok, adv, hold, good, was;
  always_comb begin
    s_ok    = $onehot(bus.phase);
    p_ok    = $onehot(ph_q);
    adv     = s_ok && p_ok && bus.phase == {ph_q[N-2:0], ph_q[N-1]};
    hold    = s_ok && p_ok && bus.phase == ph_q;
    good    = adv || hold;
    was     = state_q == LOCKED;
    ph_d    = bus.phase;
    run_d   = !s_ok ? '0 : !good ? RW'(1) : run_q == RW'(LOCK_CYCLES) ? run_q : run_q + RW'(1);
    state_d = was ? (good ? LOCKED : UNLOCKED) : (run_d == RW'(LOCK_CYCLES) ? LOCKED : UNLOCKED);
    hold_d  = (was && hold) ? (hold_q == HW'(STALL_MAX + 1) ? hold_q : hold_q + HW'(1)) : '0;
    wrap_d  = was && adv && ph_q[N-1];
    fault_d = was && !good;
    err_d   = fault_d || (err_q && !bus.clr);
    rot_d   = bus.clr ? '0 : rot_q + CW'(wrap_d);
    valid_d = s_ok;
    idx_d   = '0;
    for (int i = 0; i < N; i++) if (s_ok && bus.phase[i]) idx_d = IW'(i);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= UNLOCKED;
      ph_q    <= '0;
      run_q   <= '0;
      hold_q  <= '0;
      idx_q   <= '0;
      rot_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      rot_q   <= rot_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
      err_q   <= err_d;
    end
  end
  assign bus.idx       = idx_q;
  assign bus.valid     = valid_q;
  assign bus.locked    = state_q == LOCKED;
  assign bus.wrap      = wrap_q;
  assign bus.fault     = fault_q;
  assign bus.err       = err_q;
  assign bus.stall     = state_q == LOCKED && hold_q > HW'(STALL_MAX);
  assign bus.rotations = rot_q;
endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed plus random phase streams checked against an index-arithmetic reference model.
module tb_ring_decoder;
  localparam int N = 4, L = 2, SM = 3, CW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  ring_if #(.N(N), .IW(2), .CW(CW)) bus();
  ring_decoder #(.N(N), .IW(2), .LOCK_CYCLES(L), .STALL_MAX(SM), .CW(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int n_chk = 0, n_pass = 0;
  logic [N-1:0] m_ph;
  int m_run, m_hold, m_rot, m_idx;
  bit m_lock, m_err, m_wrap, m_fault, m_valid;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  task automatic m_reset();
    m_ph = '0; m_run = 0; m_hold = 0; m_rot = 0; m_idx = 0;
    m_lock = 0; m_err = 0; m_wrap = 0; m_fault = 0; m_valid = 0;
  endtask
  task automatic check_all();
    chk("idx", int'(bus.idx), m_idx);
    chk("valid", int'(bus.valid), int'(m_valid));
    chk("locked", int'(bus.locked), int'(m_lock));
    chk("wrap", int'(bus.wrap), int'(m_wrap));
    chk("fault", int'(bus.fault), int'(m_fault));
    chk("err", int'(bus.err), int'(m_err));
    chk("stall", int'(bus.stall), int'(m_lock && m_hold > SM));
    chk("rotations", int'(bus.rotations), m_rot);
  endtask
  // Legality is judged on indices: a step is a hold (same index) or an advance (index+1 mod N).
  task automatic model(input logic [N-1:0] s, input bit c);
    bit sl = $countones(s) == 1;
    bit pl = $countones(m_ph) == 1;
    int si = sl ? $clog2(s) : 0;
    int pi = pl ? $clog2(m_ph) : 0;
    bit hd = sl && pl && si == pi;
    bit av = sl && pl && si == (pi + 1) % N;
    bit good = hd || av;
    bit was = m_lock;
    m_run   = !sl ? 0 : good ? (m_run + 1 > L ? L : m_run + 1) : 1;
    m_fault = was && !good;
    m_wrap  = was && av && pi == N - 1;
    m_lock  = was ? good : m_run == L;
    m_hold  = (was && hd) ? (m_hold + 1 > SM + 1 ? SM + 1 : m_hold + 1) : 0;
    m_err   = m_fault || (m_err && !c);
    m_rot   = c ? 0 : (m_rot + int'(m_wrap)) % (1 << CW);
    m_idx   = si;
    m_valid = sl;
    m_ph    = s;
  endtask
  task automatic step(input logic [N-1:0] p, input bit c = 1'b0);
    bus.phase = p;
    bus.clr = c;
    @(posedge clk);
    model(p, c);
    #1 check_all();
  endtask
  task automatic areset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_reset();
    check_all();
    #1 reset = 1'b0;
  endtask
  function automatic logic [N-1:0] pick(input logic [N-1:0] cur);
    int k = $countones(cur) == 1 ? $clog2(cur) : int'($urandom_range(0, N - 1));
    int r = int'($urandom_range(0, 9));
    logic [N-1:0] one = 1;
    return r < 5 ? one << ((k + 1) % N) : r < 7 ? one << k : r == 7 ? one << ((k + 2) % N) :
           r == 8 ? N'($urandom) : '0;
  endfunction
  initial begin
    bus.phase = '0;
    bus.clr = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) reset = 1'b0;
    step(4'b0001);
    chk("lock_early", int'(bus.locked), 0);
    step(4'b0010);
    chk("lock_after_2", int'(bus.locked), 1);
    step(4'b0100);
    step(4'b1000);
    chk("idx3", int'(bus.idx), 3);
    step(4'b0001);
    chk("wrap_pulse", int'(bus.wrap), 1);
    chk("rot_one", int'(bus.rotations), 1);
    step(4'b0010);
    step(4'b0100);
    repeat (3) step(4'b0100);
    chk("stall_pre", int'(bus.stall), 0);
    step(4'b0100);
    chk("stall_set", int'(bus.stall), 1);
    chk("hold_idx", int'(bus.idx), 2);
    step(4'b1000);
    chk("stall_clr", int'(bus.stall), 0);
    step(4'b0001);
    step(4'b0010);
    step(4'b1000);
    chk("skip_fault", int'(bus.fault), 1);
    chk("skip_unlock", int'(bus.locked), 0);
    chk("skip_err", int'(bus.err), 1);
    step(4'b0001);
    chk("relock", int'(bus.locked), 1);
    step(4'b0110);
    chk("bad_valid", int'(bus.valid), 0);
    chk("bad_fault", int'(bus.fault), 1);
    step(4'b0001);
    step(4'b0010);
    step(4'b0110, 1'b1);
    chk("clr_vs_fault", int'(bus.err), 1);
    step(4'b0001, 1'b1);
    chk("clr_err", int'(bus.err), 0);
    chk("clr_rot", int'(bus.rotations), 0);
    step(4'b0010);
    step(4'b0100);
    step(4'b1000);
    for (int r = 0; r < 4; r++) for (int k = 0; k < N; k++) step(4'b0001 << k);
    chk("rot_modulo", int'(bus.rotations), 0);
    areset();
    chk("areset_locked", int'(bus.locked), 0);
    step(4'b0001);
    chk("post_reset_valid", int'(bus.valid), 1);
    repeat (800) begin
      if ($urandom_range(0, 199) == 0) areset();
      else step(pick(bus.phase), $urandom_range(0, 15) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
